mem_write_d_pp: RTL and testbench

Ping-pong write-address generator for the D-operand buffer: the write-side counterpart of the D read sequencer feeding the systolic array. Accepts a valid/ready stream of D words, steers each word to one of N1 per-row RAM lanes (one-hot enable), generates the in-bank address (column, block offset), and alternates between two banks. Reports bank completion to the read side and stalls the stream while the target bank is still owned by the reader.

---
 rtl/mem_write_d_pp_pkg.sv | 22 ++
 rtl/pp_bank_tracker.sv | 62 ++++++
 rtl/mem_write_d_pp.sv | 140 ++++++++++++++
 tb/tb_mem_write_d_pp.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_d_pp_pkg.sv
// Shared definitions for the D-operand ping-pong buffer (write and read sides).
//   bank_id_t      : one-bit bank selector.
//   bank_base()    : base address of a bank inside an addr_w-bit RAM address
//                    space (bank bit is the address MSB).
//   lane_oh_t      : one-hot lane enable for the default row count.
//   lane_first()   : one-hot value of lane 0 for an n1-lane array.
package mem_write_d_pp_pkg;

  typedef logic bank_id_t;

  localparam int unsigned LANE_N1_DEFAULT = 4;
  typedef logic [LANE_N1_DEFAULT-1:0] lane_oh_t;

  function automatic logic [31:0] bank_base(input bank_id_t b, input int unsigned addr_w);
    return 32'(b) << (addr_w - 1);
  endfunction

  function automatic logic [31:0] lane_first(input int unsigned n1);
    return (n1 == 0) ? '0 : 32'd1;
  endfunction

endpackage

// File: rtl/pp_bank_tracker.sv
// Ping-pong bank ownership tracker.
//   i_clk, i_rst_n : clock, asynchronous active-low reset.
//   i_bank_end     : accepted beat is the last word of the current write bank.
//   i_rd_release   : reader frees the oldest full bank (one-cycle pulse).
//   o_wr_bank      : bank currently being written.
//   o_rd_bank      : bank the reader owns next (oldest full).
//   o_release_err  : sticky, release seen while no bank was full.
//   o_ready        : write side may accept a word.
module pp_bank_tracker
  import mem_write_d_pp_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_bank_end,
  input  logic     i_rd_release,
  output bank_id_t o_wr_bank,
  output bank_id_t o_rd_bank,
  output logic     o_release_err,
  output logic     o_ready
);

  logic [1:0] r_bank_full;
  bank_id_t   r_wr_bank;
  bank_id_t   r_rd_bank;
  logic       r_release_err;

  logic [1:0] w_full_set;
  logic [1:0] w_full_clr;
  logic       w_release_ok;

  // Set and clear look at registered state, so a bank-end and a release in
  // the same cycle both take effect; they can never target the same bank
  // because the bank being written is never full.
  always_comb begin
    w_release_ok = i_rd_release && (|r_bank_full);
    w_full_set   = '0;
    w_full_clr   = '0;
    if (i_bank_end)   w_full_set[r_wr_bank] = 1'b1;
    if (w_release_ok) w_full_clr[r_rd_bank] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank_full   <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_release_err <= 1'b0;
    end else begin
      r_bank_full <= (r_bank_full & ~w_full_clr) | w_full_set;
      if (i_bank_end)   r_wr_bank <= ~r_wr_bank;
      if (w_release_ok) r_rd_bank <= ~r_rd_bank;
      if (i_rd_release && !(|r_bank_full)) r_release_err <= 1'b1;
    end
  end

  assign o_wr_bank     = r_wr_bank;
  assign o_rd_bank     = r_rd_bank;
  assign o_release_err = r_release_err;
  // Held low during reset; otherwise purely registered state.
  assign o_ready       = i_rst_n & ~r_bank_full[r_wr_bank];

endmodule

// File: rtl/mem_write_d_pp.sv
// Ping-pong write-address generator for the D-operand buffer.
//   clk, rst_n            : clock, asynchronous active-low reset.
//   BLOCK_NUM, BLOCK_WIDTH: blocks per lane per bank (0 acts as 1), words per block.
//   s_valid/s_ready/s_data: input word stream.
//   wr_en_D/wr_addr_D/wr_data_D : registered one-hot lane write port.
//   bank_done, bank_done_id     : pulse with the final write of a bank.
//   rd_release, rd_bank         : reader handshake, bank the reader owns next.
//   release_err                 : sticky, release with no full bank.
module mem_write_d_pp
  import mem_write_d_pp_pkg::*;
#(
  parameter int unsigned N1           = 4,
  parameter int unsigned MATRIXSIZE_W = 16,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [MATRIXSIZE_W-1:0] BLOCK_NUM,
  input  logic [MATRIXSIZE_W-1:0] BLOCK_WIDTH,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  output logic [N1-1:0]           wr_en_D,
  output logic [ADDR_W-1:0]       wr_addr_D,
  output logic [DATA_W-1:0]       wr_data_D,
  output logic                    bank_done,
  output logic                    bank_done_id,
  input  logic                    rd_release,
  output logic                    rd_bank,
  output logic                    release_err
);

  logic [MATRIXSIZE_W-1:0] r_col;
  logic [MATRIXSIZE_W-1:0] r_blk_idx;
  logic [MATRIXSIZE_W-1:0] r_blk_off;
  logic [N1-1:0]           r_lane;

  logic [N1-1:0]           r_wr_en;
  logic [ADDR_W-1:0]       r_wr_addr;
  logic [DATA_W-1:0]       r_wr_data;
  logic                    r_bank_done;
  logic                    r_bank_done_id;

  logic                    w_ready;
  logic                    w_accept;
  bank_id_t                w_wr_bank;
  bank_id_t                w_rd_bank;
  logic                    w_release_err;
  logic [MATRIXSIZE_W-1:0] w_blk_num_eff;
  logic                    w_col_wrap;
  logic                    w_blk_wrap;
  logic                    w_lane_last;
  logic                    w_bank_end;
  logic [MATRIXSIZE_W-1:0] w_offset;
  logic [ADDR_W-1:0]       w_addr;

  always_comb begin
    w_accept      = s_valid && w_ready;
    w_blk_num_eff = (BLOCK_NUM == '0) ? MATRIXSIZE_W'(1) : BLOCK_NUM;
    w_col_wrap    = (r_col == BLOCK_WIDTH - MATRIXSIZE_W'(1));
    w_blk_wrap    = (r_blk_idx == w_blk_num_eff - MATRIXSIZE_W'(1));
    w_lane_last   = r_lane[N1-1];
    w_bank_end    = w_accept && w_col_wrap && w_blk_wrap && w_lane_last;
    w_offset      = r_blk_off + r_col;
    w_addr        = ADDR_W'(bank_base(w_wr_bank, ADDR_W))
                  | {1'b0, w_offset[ADDR_W-2:0]};
  end

  pp_bank_tracker u_bank_tracker (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_bank_end    (w_bank_end),
    .i_rd_release  (rd_release),
    .o_wr_bank     (w_wr_bank),
    .o_rd_bank     (w_rd_bank),
    .o_release_err (w_release_err),
    .o_ready       (w_ready)
  );

  // Address / lane counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_blk_idx <= '0;
      r_blk_off <= '0;
      r_lane    <= N1'(lane_first(N1));
    end else if (w_accept) begin
      if (w_bank_end) begin
        r_col     <= '0;
        r_blk_idx <= '0;
        r_blk_off <= '0;
        r_lane    <= N1'(lane_first(N1));
      end else if (w_col_wrap) begin
        r_col <= '0;
        if (w_blk_wrap) begin
          r_blk_idx <= '0;
          r_blk_off <= '0;
          r_lane    <= {r_lane[N1-2:0], r_lane[N1-1]};
        end else begin
          r_blk_idx <= r_blk_idx + MATRIXSIZE_W'(1);
          r_blk_off <= r_blk_off + BLOCK_WIDTH;
        end
      end else begin
        r_col <= r_col + MATRIXSIZE_W'(1);
      end
    end
  end

  // Registered write port: one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en        <= '0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_bank_done    <= 1'b0;
      r_bank_done_id <= 1'b0;
    end else begin
      r_bank_done <= w_bank_end;
      if (w_bank_end) r_bank_done_id <= w_wr_bank;
      if (w_accept) begin
        r_wr_en   <= r_lane;
        r_wr_addr <= w_addr;
        r_wr_data <= s_data;
      end else begin
        r_wr_en   <= '0;
      end
    end
  end

  assign s_ready      = w_ready;
  assign wr_en_D      = r_wr_en;
  assign wr_addr_D    = r_wr_addr;
  assign wr_data_D    = r_wr_data;
  assign bank_done    = r_bank_done;
  assign bank_done_id = r_bank_done_id;
  assign rd_bank      = w_rd_bank;
  assign release_err  = w_release_err;

endmodule

// File: tb/tb_mem_write_d_pp.sv
module tb_mem_write_d_pp;

  logic        clk;
  logic        rst_n;
  logic [15:0] BLOCK_NUM;
  logic [15:0] BLOCK_WIDTH;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  wr_en_D;
  logic [11:0] wr_addr_D;
  logic [31:0] wr_data_D;
  logic        bank_done;
  logic        bank_done_id;
  logic        rd_release;
  logic        rd_bank;
  logic        release_err;

  int vec_cnt;
  int err_cnt;

  mem_write_d_pp #(
    .N1           (4),
    .MATRIXSIZE_W (16),
    .ADDR_W       (12),
    .DATA_W       (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .BLOCK_NUM    (BLOCK_NUM),
    .BLOCK_WIDTH  (BLOCK_WIDTH),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .wr_en_D      (wr_en_D),
    .wr_addr_D    (wr_addr_D),
    .wr_data_D    (wr_data_D),
    .bank_done    (bank_done),
    .bank_done_id (bank_done_id),
    .rd_release   (rd_release),
    .rd_bank      (rd_bank),
    .release_err  (release_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat with its expected registered result.
  task automatic do_beat(input string tag, input int idx, input logic [3:0] exp_lane,
                         input logic [11:0] exp_addr, input logic exp_done, input logic exp_id);
    logic [31:0] d;
    d = 32'hD000_0000 + 32'(idx);
    vec_cnt++;
    if (s_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s ready beat %0d: got %b want 1", tag, idx, s_ready);
    end
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
    vec_cnt++;
    if (wr_en_D !== exp_lane) begin
      err_cnt++;
      $display("FAIL %s lane beat %0d: got %b want %b", tag, idx, wr_en_D, exp_lane);
    end
    vec_cnt++;
    if (wr_addr_D !== exp_addr) begin
      err_cnt++;
      $display("FAIL %s addr beat %0d: got %0d want %0d", tag, idx, wr_addr_D, exp_addr);
    end
    vec_cnt++;
    if (wr_data_D !== d) begin
      err_cnt++;
      $display("FAIL %s data beat %0d: got %h want %h", tag, idx, wr_data_D, d);
    end
    vec_cnt++;
    if (bank_done !== exp_done) begin
      err_cnt++;
      $display("FAIL %s bank_done beat %0d: got %b want %b", tag, idx, bank_done, exp_done);
    end
    if (exp_done) begin
      vec_cnt++;
      if (bank_done_id !== exp_id) begin
        err_cnt++;
        $display("FAIL %s bank_done_id beat %0d: got %b want %b", tag, idx, bank_done_id, exp_id);
      end
    end
  endtask

  // Beats [first, last] of one bank; per-bank words = 4 * bn * bw, beat numbering global.
  task automatic run_bank(input string tag, input int first, input int last, input int bn,
                          input int bw, input logic bank);
    int per_lane;
    int w;
    logic [3:0]  el;
    logic [11:0] ea;
    per_lane = bn * bw;
    for (int b = first; b <= last; b++) begin
      w  = b % (4 * per_lane);
      el = 4'(1 << (w / per_lane));
      ea = {bank, 11'(w % per_lane)};
      do_beat(tag, b, el, ea, (w == 4 * per_lane - 1), bank);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic check_idle(input string tag);
    vec_cnt++;
    if (s_ready !== 1'b0 || wr_en_D !== 4'b0 || wr_addr_D !== 12'd0 || wr_data_D !== 32'd0 ||
        bank_done !== 1'b0 || bank_done_id !== 1'b0 || rd_bank !== 1'b0 || release_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s: got rdy=%b en=%b addr=%0d data=%h done=%b id=%b rdb=%b err=%b want all 0",
               tag, s_ready, wr_en_D, wr_addr_D, wr_data_D, bank_done, bank_done_id, rd_bank, release_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    check_idle("reset_values");
    rst_n = 1'b1;
    #1;
    vec_cnt++;
    if (s_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_ready_after: got %b want 1", s_ready);
    end
  endtask

  task automatic test_basic();
    BLOCK_NUM = 16'd2;
    BLOCK_WIDTH = 16'd3;
    // beats 0-2 addr 0..2 lane 0001; 3-5 addr 3..5; 6 lane 0010 addr 0; 23 lane 1000 addr 5 done id 0
    do_beat("basic", 0, 4'b0001, 12'd0, 1'b0, 1'b0);
    do_beat("basic", 1, 4'b0001, 12'd1, 1'b0, 1'b0);
    do_beat("basic", 2, 4'b0001, 12'd2, 1'b0, 1'b0);
    do_beat("basic", 3, 4'b0001, 12'd3, 1'b0, 1'b0);
    do_beat("basic", 4, 4'b0001, 12'd4, 1'b0, 1'b0);
    do_beat("basic", 5, 4'b0001, 12'd5, 1'b0, 1'b0);
    do_beat("basic", 6, 4'b0010, 12'd0, 1'b0, 1'b0);
    run_bank("basic", 7, 22, 2, 3, 1'b0);
    do_beat("basic", 23, 4'b1000, 12'd5, 1'b1, 1'b0);
  endtask

  task automatic test_second_bank();
    do_beat("bank1", 24, 4'b0001, 12'd2048, 1'b0, 1'b0);
    run_bank("bank1", 25, 46, 2, 3, 1'b1);
    do_beat("bank1", 47, 4'b1000, 12'd2053, 1'b1, 1'b1);
    // both banks full: valid held high must not produce writes
    s_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      vec_cnt++;
      if (s_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL stall_ready cyc %0d: got %b want 0", c, s_ready);
      end
      tick();
      vec_cnt++;
      if (wr_en_D !== 4'b0000) begin
        err_cnt++;
        $display("FAIL stall_no_write cyc %0d: got %b want 0000", c, wr_en_D);
      end
    end
    s_valid = 1'b0;
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    vec_cnt++;
    if (rd_bank !== 1'b1 || s_ready !== 1'b1 || release_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL release_unstall: got rd_bank=%b ready=%b err=%b want 1 1 0", rd_bank, s_ready, release_err);
    end
    do_beat("bank0_again", 48, 4'b0001, 12'd0, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    // bank 1 is full; release it in the same cycle as the last beat of bank 0
    run_bank("simul", 49, 70, 2, 3, 1'b0);
    rd_release = 1'b1;
    do_beat("simul", 71, 4'b1000, 12'd5, 1'b1, 1'b0);
    rd_release = 1'b0;
    vec_cnt++;
    if (rd_bank !== 1'b0 || release_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL simul_release: got rd_bank=%b err=%b want 0 0", rd_bank, release_err);
    end
    do_beat("simul_next", 72, 4'b0001, 12'd2048, 1'b0, 1'b0);
    do_beat("simul_next", 73, 4'b0001, 12'd2049, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_bank();
    apply_reset();
    BLOCK_NUM = 16'd2;
    BLOCK_WIDTH = 16'd3;
    run_bank("mid", 0, 10, 2, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle("mid_reset_values");
    tick();
    rst_n = 1'b1;
    #1;
    do_beat("mid_after", 0, 4'b0001, 12'd0, 1'b0, 1'b0);
    run_bank("mid_after", 1, 22, 2, 3, 1'b0);
    do_beat("mid_after", 23, 4'b1000, 12'd5, 1'b1, 1'b0);
  endtask

  task automatic test_block_num_zero();
    apply_reset();
    BLOCK_NUM = 16'd0;
    BLOCK_WIDTH = 16'd2;
    do_beat("bn0", 0, 4'b0001, 12'd0, 1'b0, 1'b0);
    do_beat("bn0", 1, 4'b0001, 12'd1, 1'b0, 1'b0);
    do_beat("bn0", 2, 4'b0010, 12'd0, 1'b0, 1'b0);
    do_beat("bn0", 3, 4'b0010, 12'd1, 1'b0, 1'b0);
    do_beat("bn0", 4, 4'b0100, 12'd0, 1'b0, 1'b0);
    do_beat("bn0", 5, 4'b0100, 12'd1, 1'b0, 1'b0);
    do_beat("bn0", 6, 4'b1000, 12'd0, 1'b0, 1'b0);
    do_beat("bn0", 7, 4'b1000, 12'd1, 1'b1, 1'b0);
    do_beat("bn0", 8, 4'b0001, 12'd2048, 1'b0, 1'b0);
    do_beat("bn0", 9, 4'b0001, 12'd2049, 1'b0, 1'b0);
  endtask

  task automatic test_spurious_release();
    apply_reset();
    BLOCK_NUM = 16'd2;
    BLOCK_WIDTH = 16'd3;
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    vec_cnt++;
    if (release_err !== 1'b1 || rd_bank !== 1'b0 || s_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL spurious_release: got err=%b rd_bank=%b ready=%b want 1 0 1", release_err, rd_bank, s_ready);
    end
    tick();
    vec_cnt++;
    if (release_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL release_err_sticky: got %b want 1", release_err);
    end
    do_beat("after_spurious", 0, 4'b0001, 12'd0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_cnt     = 0;
    err_cnt     = 0;
    rst_n       = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    rd_release  = 1'b0;
    BLOCK_NUM   = 16'd2;
    BLOCK_WIDTH = 16'd3;
    test_reset();
    test_basic();
    test_second_bank();
    test_simultaneous();
    test_reset_mid_bank();
    test_block_num_zero();
    test_spurious_release();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
